// File: rtl/ex_dcache_port_arb_pkg.sv
// Shared types and constants for the execute-stage D$ port arbiter.
package ex_dcache_port_arb_pkg;

    localparam int unsigned DCACHE_ARB_MAX_OUTSTANDING = 2;
    localparam int unsigned DCACHE_ARB_NR_PORTS        = 2;

    typedef logic [$clog2(DCACHE_ARB_NR_PORTS)-1:0] dcache_arb_id_t;

    // Pointer width for a circular buffer; a 1-deep buffer still needs one bit.
    function automatic int unsigned arb_ptr_w(int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ex_dcache_port_arb_fifo.sv
// Outstanding-ID queue: registered-output FIFO holding the requester index of each granted transaction.
module ex_dcache_port_arb_fifo
    import ex_dcache_port_arb_pkg::*;
#(
    parameter int unsigned Depth = DCACHE_ARB_MAX_OUTSTANDING,
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [Width-1:0] data_o
);

    localparam int unsigned PtrW = arb_ptr_w(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Depth-1:0][Width-1:0] mem_q;
    logic [PtrW-1:0]             rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0]             cnt_q;
    logic                        do_push, do_pop;

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/ex_dcache_port_arb.sv
// Round-robin arbiter sharing one D$ request port between NrPorts requesters,
// with stall lock and in-order response routing.
module ex_dcache_port_arb
    import ex_dcache_port_arb_pkg::*;
#(
    parameter int unsigned NrPorts        = 2,
    parameter int unsigned AddrWidth      = 64,
    parameter int unsigned DataWidth      = 64,
    parameter int unsigned MaxOutstanding = DCACHE_ARB_MAX_OUTSTANDING
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NrPorts-1:0]                  req_i,
    input  logic [NrPorts-1:0]                  we_i,
    input  logic [NrPorts-1:0][AddrWidth-1:0]   addr_i,
    input  logic [NrPorts-1:0][DataWidth-1:0]   wdata_i,
    input  logic [NrPorts-1:0][DataWidth/8-1:0] be_i,
    output logic [NrPorts-1:0]                  gnt_o,
    output logic [NrPorts-1:0]                  rvalid_o,
    output logic [DataWidth-1:0]                rdata_o,
    output logic                                mem_req_o,
    output logic                                mem_we_o,
    output logic [AddrWidth-1:0]                mem_addr_o,
    output logic [DataWidth-1:0]                mem_wdata_o,
    output logic [DataWidth/8-1:0]              mem_be_o,
    input  logic                                mem_gnt_i,
    input  logic                                mem_rvalid_i,
    input  logic [DataWidth-1:0]                mem_rdata_i
);

    localparam int unsigned IdWidth = $clog2(NrPorts);
    typedef logic [IdWidth-1:0] id_t;

    id_t  rr_ptr_q, locked_sel_q, scan_sel, sel, fifo_head;
    logic lock_q, fifo_full, fifo_empty, handshake;

    always_comb begin
        logic found;
        found    = 1'b0;
        scan_sel = rr_ptr_q;
        for (int unsigned k = 0; k < NrPorts; k++) begin
            int unsigned idx;
            idx = (int'(rr_ptr_q) + k) % NrPorts;
            if (!found && req_i[id_t'(idx)]) begin
                scan_sel = id_t'(idx);
                found    = 1'b1;
            end
        end
    end

    assign sel       = lock_q ? locked_sel_q : scan_sel;
    assign mem_req_o = rst_ni & req_i[sel] & ~fifo_full;
    assign handshake = mem_req_o & mem_gnt_i;

    assign mem_we_o    = mem_req_o & we_i[sel];
    assign mem_addr_o  = mem_req_o ? addr_i[sel]  : '0;
    assign mem_wdata_o = mem_req_o ? wdata_i[sel] : '0;
    assign mem_be_o    = mem_req_o ? be_i[sel]    : '0;
    assign rdata_o     = rst_ni ? mem_rdata_i : '0;

    always_comb begin
        gnt_o    = '0;
        rvalid_o = '0;
        if (handshake) gnt_o[sel] = 1'b1;
        if (rst_ni && mem_rvalid_i && !fifo_empty) rvalid_o[fifo_head] = 1'b1;
    end

    // A stalled requester keeps the port; a dropped locked request releases it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q     <= '0;
            lock_q       <= 1'b0;
            locked_sel_q <= '0;
        end else if (handshake) begin
            rr_ptr_q <= (sel == id_t'(NrPorts - 1)) ? '0 : sel + id_t'(1);
            lock_q   <= 1'b0;
        end else if (mem_req_o) begin
            lock_q       <= 1'b1;
            locked_sel_q <= sel;
        end else if (lock_q && !req_i[locked_sel_q]) begin
            lock_q <= 1'b0;
        end
    end

    ex_dcache_port_arb_fifo #(
        .Depth (MaxOutstanding),
        .Width (IdWidth)
    ) i_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (handshake),
        .data_i  (sel),
        .pop_i   (mem_rvalid_i),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .data_o  (fifo_head)
    );

    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(mem_rvalid_i && fifo_empty))
                else $warning("dcache arb: response with nothing outstanding dropped");
            assert (!(lock_q && !req_i[locked_sel_q]))
                else $warning("dcache arb: locked requester dropped its request");
        end
    end

endmodule
